// File: rtl/conway_pkg.sv
// Types and constants shared by the serial life core and its sequencer.
`timescale 1ns/1ps
package conway_pkg;

  localparam int DEFAULT_DATA_SIZE = 64;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_OUTPUT = 2'b10,
    MODE_STOP   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_UNLOAD
  } seq_state_t;

endpackage

// File: rtl/conway_serial_sequencer.sv
// Sequences a serial 8x8 life core through load, settle, run and unload,
// bridging the host's valid/ready bit streams to the core's serial ports.
`timescale 1ns/1ps
module conway_serial_sequencer #(
  parameter int DATA_SIZE = conway_pkg::DEFAULT_DATA_SIZE,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 KEEP,
  input  logic [GEN_WIDTH-1:0] GEN_COUNT,
  input  logic                 IN_BIT,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic                 OUT_BIT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [1:0]           CORE_MODE,
  output logic                 CORE_DATA_IN,
  input  logic                 CORE_DATA_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR
);
  import conway_pkg::*;

  localparam int CNT_W = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  seq_state_t           state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic [GEN_WIDTH-1:0] gen_q;
  logic                 done_q;
  logic                 error_q;
  mode_t                mode_d;
  logic                 data_in_d;

  assign bit_cnt_d = bit_cnt_q + CNT_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gen_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (GEN_COUNT == '0) begin
              error_q <= 1'b1;
            end else begin
              gen_q     <= GEN_COUNT;
              bit_cnt_q <= '0;
              state_q   <= KEEP ? ST_RUN : ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (IN_VALID) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= ST_SETTLE;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        // One extra load-mode edge lets core memory capture the shifted pattern.
        ST_SETTLE: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          gen_q <= gen_q - GEN_WIDTH'(1);
          if (gen_q == GEN_WIDTH'(1)) begin
            bit_cnt_q <= '0;
            state_q   <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (OUT_READY) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stalls on either stream park the core in STOP so nothing shifts.
  always_comb begin
    mode_d    = MODE_STOP;
    data_in_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        mode_d    = IN_VALID ? MODE_LOAD : MODE_STOP;
        data_in_d = IN_BIT;
      end
      ST_SETTLE: mode_d = MODE_LOAD;
      ST_RUN:    mode_d = MODE_RUN;
      ST_UNLOAD: mode_d = OUT_READY ? MODE_OUTPUT : MODE_STOP;
      default:   mode_d = MODE_STOP;
    endcase
  end

  assign CORE_MODE    = mode_d;
  assign CORE_DATA_IN = data_in_d;
  assign IN_READY     = (state_q == ST_LOAD);
  assign OUT_VALID    = (state_q == ST_UNLOAD);
  assign OUT_BIT      = CORE_DATA_OUT;
  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = done_q;
  assign ERROR        = error_q;

endmodule

// File: tb/tb_conway_serial_sequencer.sv
// Bench for conway_serial_sequencer with a behavioural serial life core attached.
`timescale 1ns/1ps
module tb_conway_serial_sequencer;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;  // cells 26,27,28
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;  // cells 19,27,35

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START, KEEP, IN_BIT, IN_VALID, OUT_READY, CORE_DATA_OUT;
  logic [15:0] GEN_COUNT;
  logic        IN_READY, OUT_BIT, OUT_VALID, CORE_DATA_IN, BUSY, DONE, ERROR;
  logic [1:0]  CORE_MODE;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  conway_serial_sequencer #(.DATA_SIZE(64), .GEN_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KEEP(KEEP), .GEN_COUNT(GEN_COUNT),
    .IN_BIT(IN_BIT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_BIT(OUT_BIT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .CORE_MODE(CORE_MODE), .CORE_DATA_IN(CORE_DATA_IN), .CORE_DATA_OUT(CORE_DATA_OUT),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  // Behavioural core: shift-in register, memory, and shift-out register.
  logic [63:0] core_sh = '0;
  logic [63:0] core_mem = '0;
  logic [63:0] core_out = '0;

  function automatic logic [63:0] life(input logic [63:0] m);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(m[(r + dr) * 8 + c + dc]);
          end
        end
        n[r * 8 + c] = (cnt == 3) || (cnt == 2 && m[r * 8 + c]);
      end
    end
    return n;
  endfunction

  assign CORE_DATA_OUT = core_out[63];

  always @(posedge CLK) begin
    case (CORE_MODE)
      2'b00: begin
        core_mem <= core_sh;
        core_sh  <= {core_sh[62:0], CORE_DATA_IN};
      end
      2'b01: begin
        core_mem <= life(core_mem);
        core_out <= life(core_mem);
      end
      2'b10: core_out <= {core_out[62:0], 1'b0};
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mode"}, 64'(CORE_MODE), 64'd3);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_in_ready"}, 64'(IN_READY), 64'd0);
    chk({tag, "_out_valid"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
    chk({tag, "_error"}, 64'(ERROR), 64'd0);
    chk({tag, "_data_in"}, 64'(CORE_DATA_IN), 64'd0);
  endtask

  typedef struct {
    logic        start;
    logic        keep;
    logic [15:0] gen;
    logic        iv;
    logic        ib;
    logic        ordy;
    logic [1:0]  mode;
    logic        busy;
    logic        irdy;
    logic        ovld;
    logic        err;
    logic        din;
  } vec_t;

  vec_t tbl[10];

  task automatic xfer(input logic keep, input logic [15:0] gen, input logic [63:0] pat,
                      input bit stall, input int abort_at, input bit inject,
                      output logic [63:0] got, output int lat,
                      output int irdy_cnt, output int err_cnt);
    int in_idx, out_idx, first_acc;
    bit done_seen;
    got = '0; lat = -1; irdy_cnt = 0; err_cnt = 0;
    in_idx = 0; out_idx = 0; first_acc = -1; done_seen = 0;
    @(negedge CLK);
    START = 1'b1; KEEP = keep; GEN_COUNT = gen; IN_VALID = 1'b0; OUT_READY = 1'b0;
    @(negedge CLK);
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      IN_VALID  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      IN_BIT    = (in_idx < 64) ? pat[63 - in_idx] : 1'b0;
      OUT_READY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      START     = inject && (in_idx == 10 || out_idx == 20);
      KEEP      = inject;
      GEN_COUNT = '0;
      #1;
      if (cyc == abort_at) begin
        chk("abort_in_run_mode", 64'(CORE_MODE), 64'd1);
        RESET = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0; KEEP = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        return;
      end
      if (DONE) begin
        done_seen = 1'b1;
        lat = (first_acc < 0) ? -1 : cyc - first_acc;
        chk("done_cycle_busy", 64'(BUSY), 64'd0);
        chk("done_bit_count", 64'(out_idx), 64'd64);
      end else begin
        if (ERROR) err_cnt++;
        if (IN_READY) irdy_cnt++;
        if (IN_READY && !IN_VALID) chk("load_gap_mode", 64'(CORE_MODE), 64'd3);
        if (OUT_VALID && !OUT_READY) chk("unload_gap_mode", 64'(CORE_MODE), 64'd3);
        if (IN_READY && IN_VALID) begin
          if (first_acc < 0) first_acc = cyc;
          in_idx++;
        end
        if (OUT_VALID && OUT_READY) begin
          if (out_idx < 64) got[63 - out_idx] = OUT_BIT;
          out_idx++;
        end
        @(negedge CLK);
      end
    end
    START = 1'b0; KEEP = 1'b0;
    if (!done_seen) begin
      chk("xfer_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge CLK);
      #1;
      chk("done_single_cycle", 64'(DONE), 64'd0);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
  endtask

  logic [63:0] got, got_ref;
  int lat, irdy_cnt, err_cnt;

  initial begin
    RESET = 1'b1; START = 1'b0; KEEP = 1'b0; GEN_COUNT = '0;
    IN_BIT = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;

    tbl[0] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'd3, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    #12;
    chk_reset_outputs("reset");
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      START = tbl[i].start; KEEP = tbl[i].keep; GEN_COUNT = tbl[i].gen;
      IN_VALID = tbl[i].iv; IN_BIT = tbl[i].ib; OUT_READY = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_mode", i), 64'(CORE_MODE), 64'(tbl[i].mode));
      chk($sformatf("vec%0d_busy", i), 64'(BUSY), 64'(tbl[i].busy));
      chk($sformatf("vec%0d_in_ready", i), 64'(IN_READY), 64'(tbl[i].irdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(OUT_VALID), 64'(tbl[i].ovld));
      chk($sformatf("vec%0d_error", i), 64'(ERROR), 64'(tbl[i].err));
      chk($sformatf("vec%0d_data_in", i), 64'(CORE_DATA_IN), 64'(tbl[i].din));
    end

    // Asynchronous reset while still in LOAD.
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_outputs("load_reset");
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0; IN_VALID = 1'b0;

    xfer(1'b0, 16'd1, BLINK_H, 1'b0, -1, 1'b0, got, lat, irdy_cnt, err_cnt);
    chk("blinker_result", got, BLINK_V);
    chk("blinker_latency", 64'(lat), 64'd130);
    chk("blinker_in_ready_cycles", 64'(irdy_cnt), 64'd64);
    got_ref = got;

    xfer(1'b1, 16'd1, BLINK_H, 1'b0, -1, 1'b0, got, lat, irdy_cnt, err_cnt);
    chk("keep_result", got, BLINK_H);
    chk("keep_no_in_ready", 64'(irdy_cnt), 64'd0);

    xfer(1'b0, 16'd1, BLINK_H, 1'b1, -1, 1'b0, got, lat, irdy_cnt, err_cnt);
    chk("stall_result", got, BLINK_V);
    chk("stall_matches_unstalled", got, got_ref);

    xfer(1'b0, 16'd1, BLINK_H, 1'b0, -1, 1'b1, got, lat, irdy_cnt, err_cnt);
    chk("inject_result", got, BLINK_V);
    chk("inject_no_error", 64'(err_cnt), 64'd0);
    chk("inject_latency", 64'(lat), 64'd130);

    xfer(1'b0, 16'd5, BLINK_H, 1'b0, 67, 1'b0, got, lat, irdy_cnt, err_cnt);
    repeat (2) @(negedge CLK);
    xfer(1'b0, 16'd2, BLINK_H, 1'b0, -1, 1'b0, got, lat, irdy_cnt, err_cnt);
    chk("after_reset_gen2_result", got, BLINK_H);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conway_serial_sequencer.md
Name: conway_serial_sequencer

Overview:
- Controller that sequences one serial 8x8 life core through load, run and unload.
- Drives the core's 2-bit MODE and DATA_IN; receives the core's DATA_OUT.
- Presents the host with a start command, a generation count, and valid/ready bit streams for the initial pattern in and the result pattern out.
- Sits between the host I/O logic and the core; shares the core's CLK and RESET.

Parameters:
- DATA_SIZE, 64, number of cells (bits) per pattern.
- GEN_WIDTH, 16, width of the generation count.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  single-cycle command pulse, sampled in IDLE only.
- KEEP  input  1  sampled with START. 1 = skip LOAD and continue from the pattern already in core memory.
- GEN_COUNT  input  GEN_WIDTH  number of generations to run. Sampled with START.
- IN_BIT  input  1  initial-pattern bit from the host.
- IN_VALID  input  1  IN_BIT is valid.
- IN_READY  output  1  sequencer accepts IN_BIT this cycle.
- OUT_BIT  output  1  result bit to the host.
- OUT_VALID  output  1  OUT_BIT is valid.
- OUT_READY  input  1  host accepts OUT_BIT this cycle.
- CORE_MODE  output  2  core mode: 00 load, 01 run, 10 output, 11 stop/hold.
- CORE_DATA_IN  output  1  serial data to the core.
- CORE_DATA_OUT  input  1  serial data from the core.
- BUSY  output  1  high in any state except IDLE.
- DONE  output  1  one-cycle pulse when the last result bit is accepted.
- ERROR  output  1  one-cycle pulse when a START is rejected.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, all counters 0;
  - CORE_MODE=11, IN_READY=0, OUT_VALID=0, BUSY=0, DONE=0, ERROR=0;
  - CORE_DATA_IN=0.
- Reset mid-operation abandons the transfer. The host must restart with KEEP=0.
- States: IDLE, LOAD, SETTLE, RUN, UNLOAD.
- IDLE:
  - CORE_MODE=11 (core memory and shift registers hold).
  - On START with GEN_COUNT==0: ERROR pulses the next cycle; stay in IDLE.
  - Otherwise latch GEN_COUNT into gen_remaining.
  - Then go to LOAD if KEEP=0, or RUN if KEEP=1.
  - START outside IDLE is ignored; no ERROR.
- LOAD:
  - IN_READY=1.
  - CORE_MODE=00 when IN_VALID=1, else 11 (stall).
  - CORE_DATA_IN=IN_BIT (combinational).
  - bit_cnt increments per accepted bit.
  - After DATA_SIZE accepted bits, go to SETTLE.
  - CORE_MODE and CORE_DATA_IN are combinational from state, IN_VALID and IN_BIT. This is a documented host-to-core path.
- SETTLE (exactly 1 cycle):
  - CORE_MODE=00, CORE_DATA_IN=0, IN_READY=0.
  - Core memory captures the fully shifted pattern on this edge; the core's shift-register content afterwards is don't-care.
  - Go to RUN.
- RUN:
  - CORE_MODE=01 for exactly gen_remaining cycles; decrement per cycle.
  - When the count reaches 0, go to UNLOAD with bit_cnt=0.
  - After the final RUN edge, core memory and the core output register both hold generation N.
- UNLOAD:
  - OUT_VALID=1, OUT_BIT=CORE_DATA_OUT.
  - CORE_MODE=10 when OUT_READY=1, else 11 (hold; output register frozen).
  - bit_cnt increments per accepted bit.
  - On the DATA_SIZE-th accepted bit: DONE pulses the following cycle and the state returns to IDLE.
- Bit order equals the core's native shift order for both streams. The sequencer never reorders bits.
- Widths:
  - bit_cnt is $clog2(DATA_SIZE+1) bits.
  - gen_remaining is GEN_WIDTH bits.
  - Maximum GEN_COUNT is 2^GEN_WIDTH-1; no wrap.
- Back-to-back transfers: START is accepted in the cycle after UNLOAD returns to IDLE, i.e. the DONE cycle.
- KEEP=1 continues from core memory. The previous UNLOAD does not modify memory, because mode 10 does not write memory.

Decomposition:
- Shared package conway_pkg holds:
  - mode_t enum (MODE_LOAD=2'b00, MODE_RUN=2'b01, MODE_OUTPUT=2'b10, MODE_STOP=2'b11), also used by the core's decoder;
  - seq_state_t enum;
  - DATA_SIZE default constant.
- No sub-module: one FSM plus two counters in a single module.

Test Plan:
- Blinker: load 64 bits with bits 26,27,28 set, GEN_COUNT=1, KEEP=0, valid/ready always high → 64 output bits with exactly 19,27,35 set; DONE one cycle after the last bit; total latency 64+1+1+64 cycles from the first IN accept.
- Backpressure: same pattern with random IN_VALID and OUT_READY gaps → CORE_MODE=11 in every gap cycle; output identical to the unstalled run.
- GEN_COUNT=0 with START → ERROR pulse, BUSY stays 0, CORE_MODE stays 11.
- KEEP chain: blinker GEN=1, then START KEEP=1 GEN=1 → second output has bits 26,27,28 set; no IN_READY in the second run.
- RESET asserted mid-RUN (gen 3 of 5) → outputs take reset values immediately (asynchronous); a subsequent full load with GEN=2 returns the blinker in its original phase.
- START pulsed during LOAD and during UNLOAD → ignored: no state change, no ERROR, results unaffected.
